// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, requests instruction words, latches the response.
// Optional misaligned-PC fault detection is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch #(
  parameter logic [31:0] RESET_VECTOR      = 32'h0000_0000,
  parameter logic [2:0]  CTRL_STATE_FETCH  = 3'd0,
  parameter logic [2:0]  CTRL_STATE_DECODE = 3'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state_reg,
  output logic [2:0]  fetch_next,
  output logic        imem_read_req_valid,
  output logic [31:0] imem_read_req_addr,
  input  logic        imem_read_res_valid,
  input  logic [31:0] imem_read_res_data,
  input  logic        pc_write,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [31:0] fetch_count,
  output logic        fetch_fault
);

  localparam logic [31:0] InstrNop = 32'h0000_0013;

  logic in_fetch;
  logic accept;

  assign in_fetch            = (state_reg == CTRL_STATE_FETCH);
  assign imem_read_req_valid = in_fetch && !fetch_fault;
  assign imem_read_req_addr  = pc;
  assign pc_plus4            = pc + 32'd4;

  // A response only counts while the request is actually being presented.
  assign accept     = imem_read_req_valid && imem_read_res_valid;
  assign fetch_next = accept ? CTRL_STATE_DECODE : CTRL_STATE_FETCH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_VECTOR;
      instr       <= InstrNop;
      fetch_count <= 32'd0;
    end else begin
      if (pc_write) begin
        pc <= pc_src ? pc_target : pc_plus4;
      end
      if (accept) begin
        instr       <= imem_read_res_data;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // pc_write wins so the fault is re-evaluated against the freshly written PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_fault <= 1'b0;
    end else if (pc_write) begin
      fetch_fault <= 1'b0;
    end else if (in_fetch && (pc[1:0] != 2'b00)) begin
      fetch_fault <= 1'b1;
    end
  end
`else
  assign fetch_fault = 1'b0;
`endif

endmodule
